// File: rtl/gpio_input_controller.sv
// GPIO input port on the data-memory bus.
// Pins are double-flop synchronised, then debounced per pin. Debounced rising and
// falling edges latch into sticky pending flags that software clears by writing 1s.
// A registered level interrupt is raised when any pending flag is also enabled.
module gpio_input_controller #(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DEBOUNCE_CYCLES = 4,
  parameter int                    CNT_WIDTH       = 3,
  parameter logic [ADDR_WIDTH-1:0] DATA_ADDR       = 32'h10010028,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR     = 32'h1001002C,
  parameter logic [ADDR_WIDTH-1:0] IRQ_EN_ADDR     = 32'h10010030
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_ram,
  input  logic                  we,
  input  logic [31:0]           wdata,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [31:0]           rdata,
  output logic                  read_hit,
  output logic                  irq
);

  // Terminal count: a pin change is accepted on the edge where the counter sits here.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Synchroniser flops.
  logic [DATA_WIDTH-1:0] sync1_q;
  logic [DATA_WIDTH-1:0] sync2_q;

  // Debounced levels and per-pin stability counters.
  logic [DATA_WIDTH-1:0]                deb_q;
  logic [DATA_WIDTH-1:0]                deb_d;
  logic [DATA_WIDTH-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0][CNT_WIDTH-1:0] cnt_d;

  // Pending event flags, interrupt enables and the registered interrupt.
  logic [DATA_WIDTH-1:0]   rise_q;
  logic [DATA_WIDTH-1:0]   rise_d;
  logic [DATA_WIDTH-1:0]   fall_q;
  logic [DATA_WIDTH-1:0]   fall_d;
  logic [2*DATA_WIDTH-1:0] irq_en_q;
  logic [2*DATA_WIDTH-1:0] irq_en_d;
  logic                    irq_q;

  // Bus write decode and derived edge/clear masks.
  logic                  status_wr;
  logic                  irq_en_wr;
  logic [DATA_WIDTH-1:0] rise_set;
  logic [DATA_WIDTH-1:0] fall_set;
  logic [DATA_WIDTH-1:0] rise_clr;
  logic [DATA_WIDTH-1:0] fall_clr;

  assign status_wr = we && (addr_ram == STATUS_ADDR);
  assign irq_en_wr = we && (addr_ram == IRQ_EN_ADDR);

  // Bits of the write bus above the status/enable fields carry no meaning here.
  generate
    if (2 * DATA_WIDTH < 32) begin : g_wdata_spare
      logic unused_wdata;
      assign unused_wdata = ^wdata[31:2*DATA_WIDTH];
    end
  endgenerate

  // Two-flop synchroniser per pin; nothing sits between the flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: a pin must differ from its debounced level for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Debounced level and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // Pending flag next state: edges are detected on the same edge the debounced level
  // changes, and a set beats a simultaneous software clear of the same bit.
  always_comb begin
    rise_set = deb_d & ~deb_q;
    fall_set = ~deb_d & deb_q;
    rise_clr = status_wr ? wdata[DATA_WIDTH-1:0] : '0;
    fall_clr = status_wr ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
    irq_en_d = irq_en_wr ? wdata[2*DATA_WIDTH-1:0] : irq_en_q;
  end

  // Pending flags and interrupt enable registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
    end
  end

  // Interrupt is built from registered state and registered again, so it cannot glitch;
  // it follows pending/enable changes by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |({fall_q, rise_q} & irq_en_q);
    end
  end

  assign irq = irq_q;

  // Combinational read decode, zero-extended to the 32-bit bus; reads never change state.
  always_comb begin
    rdata    = 32'h0;
    read_hit = 1'b0;
    if (addr_ram == DATA_ADDR) begin
      rdata    = 32'(deb_q);
      read_hit = 1'b1;
    end else if (addr_ram == STATUS_ADDR) begin
      rdata    = 32'({fall_q, rise_q});
      read_hit = 1'b1;
    end else if (addr_ram == IRQ_EN_ADDR) begin
      rdata    = 32'(irq_en_q);
      read_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_gpio_input_controller.sv
// Scoreboard bench for gpio_input_controller (DATA_WIDTH=8, DEBOUNCE_CYCLES=4).
`timescale 1ns/1ps
module tb_gpio_input_controller;

  localparam logic [31:0] A_DATA   = 32'h10010028;
  localparam logic [31:0] A_STATUS = 32'h1001002C;
  localparam logic [31:0] A_IRQEN  = 32'h10010030;
  localparam logic [31:0] A_MISS   = 32'h10010024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_ram;
  logic        we;
  logic [31:0] wdata;
  logic [7:0]  gpio_in;
  logic [31:0] rdata;
  logic        read_hit;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  gpio_input_controller dut (
    .clk      (clk),
    .reset    (reset),
    .addr_ram (addr_ram),
    .we       (we),
    .wdata    (wdata),
    .gpio_in  (gpio_in),
    .rdata    (rdata),
    .read_hit (read_hit),
    .irq      (irq)
  );

  always #10 clk = ~clk;

  // Expected observation: sel 0 = rdata at addr, 1 = read_hit at addr, 2 = irq.
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input string tag, input logic [31:0] addr, input logic [31:0] val);
    exp_q.push_back('{tag, 0, addr, val});
  endtask

  task automatic exp_hit(input string tag, input logic [31:0] addr, input logic val);
    exp_q.push_back('{tag, 1, addr, {31'b0, val}});
  endtask

  task automatic exp_irq(input string tag, input logic val);
    exp_q.push_back('{tag, 2, A_DATA, {31'b0, val}});
  endtask

  // Pops queued expectations and compares them against the DUT, shortly after a negedge.
  task automatic flush();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      addr_ram = e.addr;
      #1;
      case (e.sel)
        0:       obs = rdata;
        1:       obs = {31'b0, read_hit};
        default: obs = {31'b0, irq};
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus write; returns at the negedge after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_ram = a;
    wdata    = d;
    we       = 1'b1;
    @(negedge clk);
    we       = 1'b0;
    wdata    = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    addr_ram = A_DATA;
    we       = 1'b0;
    wdata    = 32'h0;
    gpio_in  = 8'hFF;

    // Reset state with pins high.
    tick(2);
    exp_rd("rst_data", A_DATA, 32'h0);
    exp_rd("rst_status", A_STATUS, 32'h0);
    exp_rd("rst_irqen", A_IRQEN, 32'h0);
    exp_irq("rst_irq", 1'b0);
    flush();

    // Release: debounced level appears on the sixth edge (k+1+D with k the first edge).
    reset = 1'b1;
    tick(5);
    exp_rd("boot_data_early", A_DATA, 32'h0);
    flush();
    tick(1);
    exp_rd("boot_data", A_DATA, 32'h0000_00FF);
    exp_rd("boot_status", A_STATUS, 32'h0000_00FF);
    exp_irq("boot_irq", 1'b0);
    flush();
    tick(2);
    exp_irq("boot_irq_late", 1'b0);
    flush();
    wr(A_STATUS, 32'h0000_00FF);
    exp_rd("boot_clear", A_STATUS, 32'h0);
    flush();

    // All pins fall.
    gpio_in = 8'h00;
    tick(8);
    exp_rd("fall_data", A_DATA, 32'h0);
    exp_rd("fall_status", A_STATUS, 32'h0000_FF00);
    flush();
    wr(A_STATUS, 32'h0000_FFFF);
    exp_rd("fall_clear", A_STATUS, 32'h0);
    flush();

    // Glitch of D-1 cycles on pin 0 is rejected.
    gpio_in = 8'h01;
    tick(3);
    gpio_in = 8'h00;
    tick(10);
    exp_rd("glitch_data", A_DATA, 32'h0);
    exp_rd("glitch_status", A_STATUS, 32'h0);
    exp_irq("glitch_irq", 1'b0);
    flush();

    // A pulse of exactly D cycles on pin 1 is accepted, then falls again.
    gpio_in = 8'h02;
    tick(4);
    gpio_in = 8'h00;
    tick(12);
    exp_rd("pulse_status", A_STATUS, 32'h0000_0202);
    exp_rd("pulse_data", A_DATA, 32'h0);
    flush();
    wr(A_STATUS, 32'h0000_FFFF);

    // Rise on pin 3 with its rise interrupt enabled.
    wr(A_IRQEN, 32'h0000_0008);
    exp_rd("irqen_rd", A_IRQEN, 32'h0000_0008);
    flush();
    gpio_in = 8'h08;
    tick(5);
    exp_rd("rise_data_early", A_DATA, 32'h0);
    exp_irq("rise_irq_early", 1'b0);
    flush();
    tick(1);
    exp_rd("rise_data", A_DATA, 32'h0000_0008);
    exp_rd("rise_status", A_STATUS, 32'h0000_0008);
    exp_irq("rise_irq_lag", 1'b0);
    flush();
    tick(1);
    exp_irq("rise_irq", 1'b1);
    flush();

    // W1C clear: flag drops at once, irq one cycle later.
    wr(A_STATUS, 32'h0000_0008);
    exp_rd("clr_status", A_STATUS, 32'h0);
    exp_irq("clr_irq_lag", 1'b1);
    flush();
    tick(1);
    exp_irq("clr_irq", 1'b0);
    flush();

    // Fall of pin 3 coinciding with a clear of its fall bit: the set wins.
    wr(A_IRQEN, 32'h0000_0800);
    gpio_in = 8'h00;
    tick(5);
    addr_ram = A_STATUS;
    wdata    = 32'h0000_0800;
    we       = 1'b1;
    tick(1);
    we       = 1'b0;
    wdata    = 32'h0;
    exp_rd("race_status", A_STATUS, 32'h0000_0800);
    exp_rd("race_data", A_DATA, 32'h0);
    exp_irq("race_irq_lag", 1'b0);
    flush();
    tick(1);
    exp_irq("race_irq", 1'b1);
    flush();
    wr(A_STATUS, 32'h0000_0800);
    wr(A_IRQEN, 32'h0);
    tick(1);
    exp_irq("race_irq_off", 1'b0);
    flush();

    // Unmapped address decode and writes that must be ignored.
    exp_rd("miss_rdata", A_MISS, 32'h0);
    exp_hit("miss_hit", A_MISS, 1'b0);
    exp_hit("hit_data", A_DATA, 1'b1);
    exp_hit("hit_irqen", A_IRQEN, 1'b1);
    flush();
    wr(A_DATA, 32'h0000_00FF);
    wr(A_MISS, 32'h0000_FFFF);
    exp_rd("wr_data_ign", A_DATA, 32'h0);
    exp_rd("wr_miss_status", A_STATUS, 32'h0);
    exp_rd("wr_miss_irqen", A_IRQEN, 32'h0);
    flush();
    wr(A_IRQEN, 32'hFFFF_FFFF);
    exp_rd("irqen_width", A_IRQEN, 32'h0000_FFFF);
    flush();
    wr(A_IRQEN, 32'h0000_0020);

    // Reset pulse during a pin-5 debounce: everything clears and the count restarts.
    gpio_in = 8'h20;
    tick(2);
    reset = 1'b0;
    #1;
    exp_rd("mid_rst_data", A_DATA, 32'h0);
    exp_rd("mid_rst_irqen", A_IRQEN, 32'h0);
    flush();
    tick(2);
    reset = 1'b1;
    tick(5);
    exp_rd("rerun_data_early", A_DATA, 32'h0);
    exp_rd("rerun_status_early", A_STATUS, 32'h0);
    flush();
    tick(1);
    exp_rd("rerun_data", A_DATA, 32'h0000_0020);
    exp_rd("rerun_status", A_STATUS, 32'h0000_0020);
    flush();
    tick(1);
    exp_irq("rerun_irq", 1'b0);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
